// File: rtl/tinyspu_host_driver.sv
// Host-side initiator for the tinyspu pin interface: sequences the SPU reset,
// applies 16-bit commands to ui_in/uio_in and returns sampled outputs after a fixed latency.
module tinyspu_host_driver #(
   parameter int unsigned LATENCY    = 2,
   parameter int unsigned RST_CYCLES = 4,
   parameter logic [7:0]  IDLE_UI    = 8'h00
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [15:0] cmd_data,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [15:0] resp_data,
   input  logic        spu_reset_req,
   output logic        busy,
   output logic        spu_ena,
   output logic        spu_rst_n,
   output logic [7:0]  spu_ui_in,
   output logic [7:0]  spu_uio_in,
   input  logic [7:0]  spu_uo_out,
   input  logic [7:0]  spu_uio_out,
   input  logic [7:0]  spu_uio_oe
);

   localparam logic [7:0] LAT_LOAD = 8'(LATENCY - 32'd1);
   localparam logic [7:0] RST_LOAD = 8'(RST_CYCLES - 32'd1);

   typedef enum logic [1:0] {
      RSTH = 2'd0,
      IDLE = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t      state_q;
   logic [7:0]  cnt_q;
   logic        cmd_ready_q;
   logic        resp_valid_q;
   logic [15:0] resp_data_q;
   logic        busy_q;
   logic        ena_q;
   logic        rst_n_q;
   logic [7:0]  ui_q;
   logic [7:0]  uio_in_q;

   // Transaction FSM; a reset request overrides any handshake in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= RSTH;
         cnt_q        <= RST_LOAD;
         cmd_ready_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= 16'h0000;
         busy_q       <= 1'b1;
         ena_q        <= 1'b0;
         rst_n_q      <= 1'b0;
         ui_q         <= IDLE_UI;
         uio_in_q     <= IDLE_UI;
      end else if (spu_reset_req) begin
         state_q      <= RSTH;
         cnt_q        <= RST_LOAD;
         cmd_ready_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         busy_q       <= 1'b1;
         ena_q        <= 1'b0;
         rst_n_q      <= 1'b0;
         ui_q         <= IDLE_UI;
         uio_in_q     <= IDLE_UI;
      end else begin
         case (state_q)
            RSTH: begin
               if (cnt_q == 8'd0) begin
                  state_q     <= IDLE;
                  rst_n_q     <= 1'b1;
                  ena_q       <= 1'b1;
                  cmd_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - 8'd1;
               end
            end
            IDLE: begin
               if (cmd_valid && cmd_ready_q) begin
                  ui_q        <= cmd_data[7:0];
                  uio_in_q    <= cmd_data[15:8];
                  cnt_q       <= LAT_LOAD;
                  cmd_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  state_q     <= WAIT;
               end
            end
            WAIT: begin
               if (cnt_q == 8'd0) begin
                  // Undriven uio bits are masked so they never leak X/garbage.
                  resp_data_q  <= {spu_uio_out & spu_uio_oe, spu_uo_out};
                  resp_valid_q <= 1'b1;
                  state_q      <= RESP;
               end else begin
                  cnt_q <= cnt_q - 8'd1;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid_q <= 1'b0;
                  cmd_ready_q  <= 1'b1;
                  busy_q       <= 1'b0;
                  state_q      <= IDLE;
               end
            end
            default: begin
               state_q      <= RSTH;
               cnt_q        <= RST_LOAD;
               cmd_ready_q  <= 1'b0;
               resp_valid_q <= 1'b0;
               busy_q       <= 1'b1;
               ena_q        <= 1'b0;
               rst_n_q      <= 1'b0;
               ui_q         <= IDLE_UI;
               uio_in_q     <= IDLE_UI;
            end
         endcase
      end
   end

   assign cmd_ready  = cmd_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;
   assign busy       = busy_q;
   assign spu_ena    = ena_q;
   assign spu_rst_n  = rst_n_q;
   assign spu_ui_in  = ui_q;
   assign spu_uio_in = uio_in_q;

endmodule
